// File: rtl/datapath_sequencer.sv
// Three-state instruction sequencer: accepts one instruction, drives an external
// datapath core for one cycle, then writes back to a 4-entry register file.
module datapath_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [1:0]       instr_rd,
  input  logic [1:0]       instr_rs1,
  input  logic [1:0]       instr_rs2,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             done,
  output logic             err,
  output logic [3:0]       flags,
  output logic             busy,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [3:0]       op_q;
  logic [1:0]       rd_q, rs1_q, rs2_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       flg_q;
  logic [WIDTH-1:0] regs [4];
  logic             is_ldi, is_illegal;

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready is high only in IDLE, so instr_valid
  // while busy is ignored and the instr_* fields matter only at that edge.
  assign accept     = instr_valid & instr_ready;
  assign is_ldi     = (op_q == 4'b1111);
  assign is_illegal = op_q[3] & ~is_ldi;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;
  assign dbg_data   = regs[dbg_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = 4'b0000;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = EXEC;
      end
      EXEC: begin
        alu_a     = regs[rs1_q];
        alu_b     = regs[rs2_q];
        alu_op    = op_q;
        state_nxt = WB;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= 4'b0000;
      rd_q  <= 2'd0;
      rs1_q <= 2'd0;
      rs2_q <= 2'd0;
      imm_q <= '0;
      res_q <= '0;
      flg_q <= 4'b0000;
      flags <= 4'b0000;
      done  <= 1'b0;
      err   <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (accept) begin
        op_q  <= instr_op;
        rd_q  <= instr_rd;
        rs1_q <= instr_rs1;
        rs2_q <= instr_rs2;
        imm_q <= instr_imm;
      end
      if (state == EXEC) begin
        res_q <= alu_result;
        flg_q <= {alu_zero, alu_neg, alu_carry, alu_overflow};
      end
      // Writeback happens here, so the next instruction's EXEC read sees it.
      if (state == WB) begin
        done <= 1'b1;
        err  <= is_illegal;
        if (is_ldi) begin
          regs[rd_q] <= imm_q;
        end else if (!is_illegal) begin
          regs[rd_q] <= res_q;
          flags      <= flg_q;
        end
      end
    end
  end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand, register and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 instr_valid  input  1  instruction present on the instr_* fields.
REQ-005 instr_ready  output  1  sequencer can accept an instruction.
REQ-006 instr_op  input  4  opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL, 1111 LDI; 1000-1110 are illegal.
REQ-007 instr_rd, instr_rs1, instr_rs2  input  2 each  destination and source register indices.
REQ-008 instr_imm  input  WIDTH  immediate value, used by LDI only.
REQ-009 alu_a, alu_b  output  WIDTH  operands to the datapath core.
REQ-010 alu_op  output  4  opcode to the datapath core.
REQ-011 alu_result  input  WIDTH  datapath core result (combinational from alu_a, alu_b, alu_op).
REQ-012 alu_zero, alu_neg, alu_carry, alu_overflow  input  1 each  datapath core flags.
REQ-013 done  output  1  one-cycle pulse: instruction retired.
REQ-014 err  output  1  one-cycle pulse: illegal opcode retired.
REQ-015 flags  output  4  architectural flags {Z,N,C,V}.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 dbg_sel  input  2  debug read index.
REQ-018 dbg_data  output  WIDTH  R[dbg_sel], combinational.

Function
REQ-019 The block SHALL contain a register file R0-R3 of WIDTH bits each; all four registers are writable.
REQ-020 The FSM SHALL have three states, IDLE, EXEC and WB; instr_ready = 1 only in IDLE.
REQ-021 The handshake is instr_valid & instr_ready at a rising edge; on acceptance the block SHALL latch op, rd, rs1, rs2 and imm, and the FSM SHALL go IDLE->EXEC.
REQ-022 instr_valid while busy SHALL be ignored; the instr_* fields need only be stable at the accepting edge.
REQ-023 In EXEC, the block SHALL drive alu_a = R[rs1], alu_b = R[rs2] and alu_op = latched op, capture alu_result and the four flags into holding registers at the edge, and go EXEC->WB.
REQ-024 Outside EXEC, alu_a, alu_b and alu_op SHALL be driven to 0.
REQ-025 For legal ALU ops, the WB-exit edge SHALL write the held result to R[rd] and load flags = {Z,N,C,V} from the held values.
REQ-026 For ALU ops, all four flags SHALL be loaded exactly as supplied by the core; the block SHALL NOT recompute them.
REQ-027 For LDI, the WB-exit edge SHALL write the latched imm to R[rd]; flags SHALL be unchanged; the ALU result is discarded.
REQ-028 For illegal ops, no register and no flag SHALL change, and err SHALL pulse together with done.
REQ-029 The FSM SHALL go WB->IDLE unconditionally; done (and err if applicable) SHALL be high for exactly the one cycle following the WB-exit edge.
REQ-030 Latency: acceptance at edge k; register and flag write at edge k+2; done high between edges k+2 and k+3.
REQ-031 A new instruction can be accepted at edge k+3, giving a maximum throughput of one instruction per 3 cycles.
REQ-032 Reads of R[rs1] and R[rs2] occur in EXEC, after any prior writeback, so back-to-back dependent instructions SHALL see updated values with no hazard.
REQ-033 rd = rs1 or rd = rs2 SHALL be legal; sources are read before the write.
REQ-034 The SLL and SRL shift amount is supplied by the core from alu_b; the sequencer passes it unmodified.

Reset
REQ-035 While rst is high, asynchronously: state = IDLE; R0-R3 = 0; flags = 0; done = 0; err = 0; all holding registers = 0.
REQ-036 Reset asserted in EXEC or WB SHALL abort the instruction with no writeback and no done pulse.
REQ-037 instr_ready SHALL be high in the first cycle after reset release.

Verification
REQ-038 LDI R1,5; LDI R2,3; ADD R3,R1,R2 -> R3 = 8, flags = 0000, one done per instruction, done exactly 2 edges after each accept.
REQ-039 LDI R1,FF; LDI R2,01; ADD R0,R1,R2 -> R0 = 00, Z = 1, C = 1; a following LDI leaves flags unchanged.
REQ-040 LDI R1,0C; LDI R2,07; SUB R1,R1,R2 then AND R2,R1,R1 with no idle gap -> R1 = 05, R2 = 05 (dependency and rd = rs1 check).
REQ-041 op 1010 with R0-R3 preloaded -> err and done pulse together; registers and flags unchanged.
REQ-042 instr_valid held high for 10 cycles with the same ADD -> accepted at most once per 3 cycles; busy high in EXEC and WB.
REQ-043 rst asserted in EXEC of ADD R3 -> R3 = 0, no done, instr_ready = 1 after release.
